// File: rtl/ed25519_io_pkg.sv
// ============================================================================
// Module   : ed25519_io_pkg
// Brief    : Shared defaults, FSM state encoding and counter sizing helper
//            for the ed25519 stream framing front-end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ed25519_io_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int PATN_W_DEF = 256;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_word_serializer.sv
// ============================================================================
// Module   : io_word_serializer
// Brief    : Holds the core result and streams it MSB-first as DATA_W words
//            on a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_word_serializer
    import ed25519_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = 2 * PATN_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [RES_W-1:0]  i_result,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_last
);

    localparam int OW  = RES_W / DATA_W;
    localparam int OCW = cnt_width(OW);
    localparam logic [OCW-1:0] c_ow_last = OCW'(OW - 1);

    logic [RES_W-1:0] r_result;
    logic [OCW-1:0]   r_out_cnt;
    logic             r_valid;
    logic             w_hs;

    assign w_hs        = r_valid && i_out_ready;
    assign o_last      = w_hs && (r_out_cnt == c_ow_last);
    assign o_out_valid = r_valid;
    // The current word is always parked at the top; each handshake shifts up.
    assign o_out_data  = r_result[RES_W-1 -: DATA_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result  <= '0;
            r_out_cnt <= '0;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_result  <= i_result;
            r_out_cnt <= '0;
            r_valid   <= 1'b1;
        end else if (w_hs) begin
            r_result <= r_result << DATA_W;
            if (r_out_cnt == c_ow_last) begin
                r_out_cnt <= '0;
                r_valid   <= 1'b0;
            end else begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ed25519_io_frame.sv
// ============================================================================
// Module   : ed25519_io_frame
// Brief    : Stream framing front-end: deserialises operand frames, runs the
//            core start/done handshake and serialises results back out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ed25519_io_frame
    import ed25519_io_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PATN_W   = PATN_W_DEF,
    parameter int N_IN     = 3,
    parameter int N_OUT    = 2,
    parameter int PREFETCH = 1,
    parameter int CNT_W    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [DATA_W-1:0]       i_in_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [DATA_W-1:0]       o_out_data,
    output logic                    o_core_start,
    output logic [N_IN*PATN_W-1:0]  o_core_operand,
    input  logic                    i_core_done,
    input  logic [N_OUT*PATN_W-1:0] i_core_result,
    output logic [CNT_W-1:0]        o_frame_cnt,
    output logic                    o_err
);

    localparam int OP_W  = N_IN * PATN_W;
    localparam int RES_W = N_OUT * PATN_W;
    localparam int IW    = OP_W / DATA_W;
    localparam int ICW   = cnt_width(IW);
    localparam logic [ICW-1:0] c_iw_last = ICW'(IW - 1);

    state_t          r_state;
    logic [OP_W-1:0] r_shift;
    logic [ICW-1:0]  r_in_cnt;
    logic            r_full;
    logic            r_start;
    logic [OP_W-1:0] r_operand;
    logic [CNT_W-1:0] r_frame_cnt;
    logic            r_err;

    logic            w_allow;
    logic            w_in_ready;
    logic            w_in_hs;
    logic            w_in_last;
    logic [OP_W-1:0] w_shift_next;
    logic            w_load;
    logic            w_out_last;

    generate
        if (PREFETCH != 0) begin : g_prefetch
            assign w_allow = 1'b1;
        end else begin : g_single
            assign w_allow = (r_state == S_LOAD);
        end
    endgenerate

    assign w_in_ready   = !r_full && w_allow;
    // Held low while reset is asserted so every output reads zero in reset.
    assign o_in_ready   = w_in_ready && i_rst_n;
    assign w_in_hs      = i_in_valid && w_in_ready;
    assign w_in_last    = w_in_hs && (r_in_cnt == c_iw_last);
    assign w_shift_next = w_in_hs ? ((r_shift << DATA_W) | OP_W'(i_in_data)) : r_shift;
    assign w_load       = i_core_done && (r_state == S_WAIT);

    assign o_core_start   = r_start;
    assign o_core_operand = r_operand;
    assign o_frame_cnt    = r_frame_cnt;
    assign o_err          = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_LOAD;
            r_shift     <= '0;
            r_in_cnt    <= '0;
            r_full      <= 1'b0;
            r_start     <= 1'b0;
            r_operand   <= '0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (w_in_hs) begin
                r_shift <= w_shift_next;
                if (w_in_last) begin
                    r_in_cnt <= '0;
                    r_full   <= 1'b1;
                end else begin
                    r_in_cnt <= r_in_cnt + 1'b1;
                end
            end
            if (i_core_done && (r_state != S_WAIT))
                r_err <= 1'b1;
            case (r_state)
                S_LOAD: begin
                    if (r_full) begin
                        r_operand <= r_shift;
                        r_full    <= 1'b0;
                        r_start   <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (i_core_done)
                        r_state <= S_UNLOAD;
                end
                S_UNLOAD: begin
                    if (w_out_last) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        // A frame completing on this very edge is issued directly.
                        if (r_full || w_in_last) begin
                            r_operand <= w_shift_next;
                            r_full    <= 1'b0;
                            r_start   <= 1'b1;
                            r_state   <= S_ISSUE;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    io_word_serializer #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W)
    ) u_ser (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load),
        .i_result    (i_core_result),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_last      (w_out_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_ed25519_io_frame.sv
// ============================================================================
// Module   : tb_ed25519_io_frame
// Brief    : Scoreboard bench for ed25519_io_frame with a behavioural core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ed25519_io_frame;

    localparam int DATA_W = 64;
    localparam int PATN_W = 256;
    localparam int OP_W   = 3 * PATN_W;
    localparam int RES_W  = 2 * PATN_W;
    localparam int IW     = 12;
    localparam int OW     = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              core_start;
    logic [OP_W-1:0]   core_operand;
    logic              core_done_m = 1'b0;
    logic              spur_done = 1'b0;
    logic [RES_W-1:0]  core_result = '0;
    logic [15:0]       frame_cnt;
    logic              err;
    logic [1:0]        ready_mode = 2'd0;
    logic              rnd_bit = 1'b1;
    logic              man_ready = 1'b0;
    wire out_ready = (ready_mode == 2'd0) ? 1'b1 : (ready_mode == 2'd1) ? rnd_bit : man_ready;
    wire core_done = core_done_m | spur_done;

    ed25519_io_frame u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_data      (in_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_data     (out_data),
        .o_core_start   (core_start),
        .o_core_operand (core_operand),
        .i_core_done    (core_done),
        .i_core_result  (core_result),
        .o_frame_cnt    (frame_cnt),
        .o_err          (err)
    );

    // Single-buffered instance, free-running, watched for input acceptance while busy.
    logic              np_done = 1'b0;
    logic              np_in_ready, np_out_valid, np_start, np_err;
    logic [DATA_W-1:0] np_out_data;
    logic [OP_W-1:0]   np_operand;
    logic [15:0]       np_frame_cnt;

    ed25519_io_frame #(.PREFETCH(0)) u_np (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_in_valid     (1'b1),
        .o_in_ready     (np_in_ready),
        .i_in_data      (64'h0123_4567_89AB_CDEF),
        .o_out_valid    (np_out_valid),
        .i_out_ready    (1'b1),
        .o_out_data     (np_out_data),
        .o_core_start   (np_start),
        .o_core_operand (np_operand),
        .i_core_done    (np_done),
        .i_core_result  ({RES_W{1'b1}}),
        .o_frame_cnt    (np_frame_cnt),
        .o_err          (np_err)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DATA_W-1:0] word_of(input int f, input int w);
        return {8'(f), 48'h0, 8'(w + 1)};
    endfunction

    function automatic logic [OP_W-1:0] frame_op(input int f);
        logic [OP_W-1:0] op;
        op = '0;
        for (int w = 0; w < IW; w++) op[OP_W-1-DATA_W*w -: DATA_W] = word_of(f, w);
        return op;
    endfunction

    function automatic logic [DATA_W-1:0] res_word(input int f, input int w);
        return 64'hC0DE_0000_0000_0000 | (64'(f) << 16) | 64'(w);
    endfunction

    logic [OP_W-1:0]   exp_op[$];
    logic [DATA_W-1:0] exp_out[$];
    int lat = 20;
    int nstart = 0;
    int nout = 0;
    bit core_busy = 1'b0;
    int start_edge[64];
    int done_edge[64];
    int last_out_edge[64];
    int last_in_edge = 0;

    initial forever begin
        @(posedge clk);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    // Behavioural core: checks the presented frame, answers after lat cycles.
    initial forever begin
        @(negedge clk);
        if (rst_n && core_start) begin
            int f;
            logic [RES_W-1:0] r;
            f = nstart;
            nstart++;
            start_edge[f % 64] = cyc;
            core_busy = 1'b1;
            if (exp_op.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_start: got start expected none");
            end else begin
                chk("operand", core_operand, exp_op.pop_front());
            end
            repeat (lat) @(posedge clk);
            #1;
            r = '0;
            for (int w = 0; w < OW; w++) begin
                r[RES_W-1-DATA_W*w -: DATA_W] = res_word(f, w);
                exp_out.push_back(res_word(f, w));
            end
            core_result = r;
            core_done_m = 1'b1;
            done_edge[f % 64] = cyc + 1;
            @(posedge clk);
            #1 core_done_m = 1'b0;
            core_busy = 1'b0;
        end
    end

    // Output monitor: pops the scoreboard on every handshake, checks stall hold.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", OP_W'(out_valid), OP_W'(1));
                chk("hold_data", OP_W'(out_data), OP_W'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got %0h expected none", out_data);
                end else begin
                    chk("out_word", OP_W'(out_data), OP_W'(exp_out.pop_front()));
                end
                if (nout % OW == OW - 1) last_out_edge[(nout / OW) % 64] = cyc + 1;
                nout++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && np_start) begin
            repeat (30) @(posedge clk);
            #1 np_done = 1'b1;
            @(posedge clk);
            #1 np_done = 1'b0;
        end
    end

    bit np_busy = 1'b0;
    bit np_prev_ov = 1'b0;
    int np_busy_cyc = 0;
    int np_viol = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            np_busy = 1'b0;
        end else begin
            if (np_prev_ov && !np_out_valid) np_busy = 1'b0;
            if (np_start) np_busy = 1'b1;
            if (np_busy) begin
                np_busy_cyc++;
                if (np_in_ready) np_viol++;
            end
        end
        np_prev_ov = np_out_valid;
    end

    task automatic send_words(input int f, input int first, input int last, input bit rnd);
        if (first == 0) exp_op.push_back(frame_op(f));
        for (int w = first; w <= last; w++) begin
            int guard;
            bit sent;
            guard = 0;
            sent = 1'b0;
            in_data = word_of(f, w);
            while (!sent) begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                if (in_valid && in_ready) begin
                    sent = 1'b1;
                    last_in_edge = cyc + 1;
                end
                @(posedge clk);
                #1;
                guard++;
                if (!sent && guard > 2000) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: got no handshake expected word %0d of frame %0d", w, f);
                    sent = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while ((exp_op.size() != 0 || exp_out.size() != 0 || core_busy || out_valid) && g < 5000) begin
            @(posedge clk);
            #1 g++;
        end
        checks++;
        if (g >= 5000) begin
            errors++;
            $display("FAIL %s_timeout: got busy expected idle", name);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int f5_in;
        int coinc_edge;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", OP_W'(out_valid), '0);
        chk("rst_start", OP_W'(core_start), '0);
        chk("rst_frame_cnt", OP_W'(frame_cnt), '0);
        chk("rst_err", OP_W'(err), '0);
        chk("rst_in_ready", OP_W'(in_ready), '0);
        chk("rst_operand", core_operand, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", OP_W'(in_ready), OP_W'(1));
        @(posedge clk);
        #1;

        lat = 20;
        send_words(0, 0, IW - 1, 1'b0);
        wait_idle("t1");
        chk("t1_frame_cnt", OP_W'(frame_cnt), OP_W'(1));
        chk("t1_start_count", OP_W'(nstart), OP_W'(1));

        ready_mode = 2'd1;
        for (int f = 1; f <= 3; f++) send_words(f, 0, IW - 1, 1'b1);
        wait_idle("t2");
        ready_mode = 2'd0;
        chk("t2_frame_cnt", OP_W'(frame_cnt), OP_W'(4));

        lat = 100;
        send_words(4, 0, IW - 1, 1'b0);
        send_words(5, 0, IW - 1, 1'b0);
        f5_in = last_in_edge;
        @(negedge clk);
        chk("prefetch_full_ready", OP_W'(in_ready), '0);
        @(posedge clk);
        #1;
        wait_idle("t3");
        chk("prefetch_before_done", OP_W'(f5_in < done_edge[4]), OP_W'(1));
        chk("prefetch_restart", OP_W'(start_edge[5]), OP_W'(last_out_edge[4]));
        chk("t3_frame_cnt", OP_W'(frame_cnt), OP_W'(6));

        lat = 20;
        ready_mode = 2'd2;
        man_ready = 1'b0;
        send_words(6, 0, IW - 1, 1'b0);
        send_words(7, 0, IW - 2, 1'b0);
        g = 0;
        while (!out_valid && g < 1000) begin
            @(posedge clk);
            #1 g++;
        end
        chk("coinc_valid_wait", OP_W'(out_valid), OP_W'(1));
        man_ready = 1'b1;
        repeat (OW - 1) @(posedge clk);
        #1 man_ready = 1'b0;
        @(posedge clk);
        #1 man_ready = 1'b1;
        in_valid = 1'b1;
        in_data = word_of(7, IW - 1);
        @(negedge clk);
        chk("coinc_in_ready", OP_W'(in_ready), OP_W'(1));
        chk("coinc_out_valid", OP_W'(out_valid), OP_W'(1));
        coinc_edge = cyc + 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        ready_mode = 2'd0;
        wait_idle("t4");
        chk("coinc_out_edge", OP_W'(last_out_edge[6]), OP_W'(coinc_edge));
        chk("coinc_start", OP_W'(start_edge[7]), OP_W'(coinc_edge));
        chk("t4_frame_cnt", OP_W'(frame_cnt), OP_W'(8));

        chk("err_before", OP_W'(err), '0);
        spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        @(negedge clk);
        chk("spur_err", OP_W'(err), OP_W'(1));
        chk("spur_no_out", OP_W'(out_valid), '0);
        chk("spur_in_ready", OP_W'(in_ready), OP_W'(1));
        repeat (5) @(posedge clk);
        #1;
        chk("spur_err_sticky", OP_W'(err), OP_W'(1));
        chk("spur_frame_cnt", OP_W'(frame_cnt), OP_W'(8));
        chk("spur_no_start", OP_W'(nstart), OP_W'(8));

        send_words(8, 0, IW - 1, 1'b0);
        g = 0;
        while (nout < 8 * OW + 3 && g < 2000) begin
            @(posedge clk);
            #1 g++;
        end
        chk("rst_reach_word3", OP_W'(nout), OP_W'(8 * OW + 3));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", OP_W'(out_valid), '0);
        chk("mid_rst_out_data", OP_W'(out_data), '0);
        chk("mid_rst_frame_cnt", OP_W'(frame_cnt), '0);
        chk("mid_rst_err", OP_W'(err), '0);
        chk("mid_rst_operand", core_operand, '0);
        chk("mid_rst_in_ready", OP_W'(in_ready), '0);
        exp_out.delete();
        nout = 9 * OW;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", OP_W'(in_ready), OP_W'(1));
        @(posedge clk);
        #1;
        send_words(9, 0, IW - 1, 1'b0);
        wait_idle("t6");
        chk("t6_frame_cnt", OP_W'(frame_cnt), OP_W'(1));
        chk("t6_err", OP_W'(err), '0);

        chk("np_ready_while_busy", OP_W'(np_viol), '0);
        chk("np_busy_seen", OP_W'(np_busy_cyc > 0), OP_W'(1));
        chk("np_frames", OP_W'(np_frame_cnt != 16'd0), OP_W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
